// File: rtl/col2im_pkg.sv
// -----------------------------------------------------------------------------
// col2im_pkg
// Shared definitions for the col2im_2d_stream block:
//   - col2im_state_t : frame controller states (IDLE / ACCUM / DRAIN)
//   - calc_hp/calc_vp: number of kernel positions across / down the image
//   - calc_npos      : total kernel positions per frame
//   - calc_nelem     : total column elements per frame (positions * K*K)
//   - cnt_w          : counter width able to hold 0..n-1 (never below 1 bit)
// Padding is always 0, so a position count is (dim - K) / stride + 1.
// -----------------------------------------------------------------------------
package col2im_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2
   } col2im_state_t;

   function automatic int calc_hp(input int w, input int k, input int s);
      return (w - k) / s + 1;
   endfunction

   function automatic int calc_vp(input int h, input int k, input int s);
      return (h - k) / s + 1;
   endfunction

   function automatic int calc_npos(input int w, input int h, input int k, input int s);
      return calc_hp(w, k, s) * calc_vp(h, k, s);
   endfunction

   function automatic int calc_nelem(input int w, input int h, input int k, input int s);
      return calc_npos(w, h, k, s) * k * k;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/col2im_addr_gen.sv
// -----------------------------------------------------------------------------
// col2im_addr_gen
// Walks the column-element order of one frame with nested counters
// (kernel col -> kernel row -> position x -> position y) and presents the image
// pixel the current element belongs to.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the walk at element 0 (frame start)
//   adv        : current element consumed, step to the next one
//   row, col   : target pixel of the current element
//   last       : current element is the final one of the frame
// -----------------------------------------------------------------------------
module col2im_addr_gen
   import col2im_pkg::*;
#(
   parameter int IMAGE_WIDTH  = 8,
   parameter int IMAGE_HEIGHT = 8,
   parameter int KERNEL_SIZE  = 3,
   parameter int STRIDE       = 1,
   parameter int ROW_W        = cnt_w(IMAGE_HEIGHT),
   parameter int COL_W        = cnt_w(IMAGE_WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             adv,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic             last
);

   localparam int HP  = calc_hp(IMAGE_WIDTH, KERNEL_SIZE, STRIDE);
   localparam int VP  = calc_vp(IMAGE_HEIGHT, KERNEL_SIZE, STRIDE);
   localparam int KW  = cnt_w(KERNEL_SIZE);
   localparam int PXW = cnt_w(HP);
   localparam int PYW = cnt_w(VP);

   localparam logic [KW-1:0]  KMAX  = KW'(KERNEL_SIZE - 1);
   localparam logic [PXW-1:0] PXMAX = PXW'(HP - 1);
   localparam logic [PYW-1:0] PYMAX = PYW'(VP - 1);

   logic [KW-1:0]  kc;
   logic [KW-1:0]  kr;
   logic [PXW-1:0] px;
   logic [PYW-1:0] py;
   logic           kc_end;
   logic           kr_end;
   logic           px_end;
   logic           py_end;

   assign kc_end = (kc == KMAX);
   assign kr_end = (kr == KMAX);
   assign px_end = (px == PXMAX);
   assign py_end = (py == PYMAX);
   assign last   = kc_end && kr_end && px_end && py_end;

   // Target pixel: position origin scaled by stride plus kernel offset.
   assign row = ROW_W'(32'(py) * 32'(STRIDE) + 32'(kr));
   assign col = COL_W'(32'(px) * 32'(STRIDE) + 32'(kc));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kc <= '0;
         kr <= '0;
         px <= '0;
         py <= '0;
      end else if (clr) begin
         kc <= '0;
         kr <= '0;
         px <= '0;
         py <= '0;
      end else if (adv) begin
         if (!kc_end) begin
            kc <= kc + 1'b1;
         end else begin
            kc <= '0;
            if (!kr_end) begin
               kr <= kr + 1'b1;
            end else begin
               kr <= '0;
               if (!px_end) begin
                  px <= px + 1'b1;
               end else begin
                  px <= '0;
                  py <= py_end ? '0 : py + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/col2im_2d_stream.sv
// -----------------------------------------------------------------------------
// col2im_2d_stream
// Streaming col2im: accepts the im2col column stream of one frame (K*K
// elements per kernel position, positions in raster order), scatter-adds every
// element into its image pixel, then streams the reconstructed image out in
// raster order.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : begin a frame (only looked at while idle)
//   in_valid/in_ready    : column element handshake, in_data unsigned
//   out_valid/out_ready  : pixel handshake, out_data = accumulated pixel,
//                          out_last flags the bottom-right pixel
//   busy                 : frame in progress
//   done                 : single-cycle pulse after the last pixel is taken
// -----------------------------------------------------------------------------
module col2im_2d_stream
   import col2im_pkg::*;
#(
   parameter int IMAGE_WIDTH  = 8,
   parameter int IMAGE_HEIGHT = 8,
   parameter int KERNEL_SIZE  = 3,
   parameter int STRIDE       = 1,
   parameter int DATA_WIDTH   = 8,
   parameter int ACC_WIDTH    = DATA_WIDTH + $clog2(KERNEL_SIZE * KERNEL_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [ACC_WIDTH-1:0]  out_data,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
   localparam int IW   = cnt_w(NPIX);
   localparam int RW   = cnt_w(IMAGE_HEIGHT);
   localparam int CW   = cnt_w(IMAGE_WIDTH);

   localparam logic [IW-1:0] IDX_LAST = IW'(NPIX - 1);

   // Unsigned add that wraps modulo 2^ACC_WIDTH; the element is resized to the
   // accumulator width first so narrow accumulators keep only the low bits.
   function automatic logic [ACC_WIDTH-1:0] acc_wrap(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] d);
      return a + ACC_WIDTH'(d);
   endfunction

   col2im_state_t        state;
   logic [IW-1:0]        rd_idx;
   logic [ACC_WIDTH-1:0] acc [NPIX];

   logic [RW-1:0]        tgt_row;
   logic [CW-1:0]        tgt_col;
   logic                 tgt_last;
   logic                 frame_start;
   logic                 in_hs;
   logic                 out_hs;
   logic [IW-1:0]        wr_idx;
   logic [ACC_WIDTH-1:0] wr_sum;
   logic [IW-1:0]        nxt_idx;
   logic [ACC_WIDTH-1:0] nxt_pix;

   assign frame_start = (state == ST_IDLE) && start;
   assign in_hs       = in_valid && in_ready;
   assign out_hs      = out_valid && out_ready;

   col2im_addr_gen #(
      .IMAGE_WIDTH  (IMAGE_WIDTH),
      .IMAGE_HEIGHT (IMAGE_HEIGHT),
      .KERNEL_SIZE  (KERNEL_SIZE),
      .STRIDE       (STRIDE),
      .ROW_W        (RW),
      .COL_W        (CW)
   ) u_addr_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (frame_start),
      .adv   (in_hs),
      .row   (tgt_row),
      .col   (tgt_col),
      .last  (tgt_last)
   );

   assign wr_idx = IW'(32'(tgt_row) * 32'(IMAGE_WIDTH) + 32'(tgt_col));
   assign wr_sum = acc_wrap(acc[wr_idx], in_data);

   // Next pixel to present. On the final input cycle the element being written
   // may land on pixel 0 (1x1 geometry), so the fresh sum is forwarded.
   always_comb begin
      nxt_idx = '0;
      if (state == ST_DRAIN) begin
         nxt_idx = rd_idx + 1'b1;
      end
      nxt_pix = acc[nxt_idx];
      if (in_hs && (wr_idx == nxt_idx)) begin
         nxt_pix = wr_sum;
      end
   end

   // Read-modify-write happens in one cycle, so consecutive hits on the same
   // pixel always see the previous sum. Contents are cleared at frame start
   // rather than on reset.
   always_ff @(posedge clk) begin
      if (frame_start) begin
         for (int n = 0; n < NPIX; n++) begin
            acc[n] <= '0;
         end
      end else if (in_hs) begin
         acc[wr_idx] <= wr_sum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rd_idx    <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_ACCUM;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ST_ACCUM: begin
               if (in_hs && tgt_last) begin
                  state     <= ST_DRAIN;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
                  rd_idx    <= '0;
                  out_data  <= nxt_pix;
                  out_last  <= (NPIX == 1);
               end
            end
            ST_DRAIN: begin
               if (out_hs) begin
                  if (out_last) begin
                     state     <= ST_IDLE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     rd_idx   <= nxt_idx;
                     out_data <= nxt_pix;
                     out_last <= (nxt_idx == IDX_LAST);
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_col2im_2d_stream.sv
// -----------------------------------------------------------------------------
// tb_col2im_2d_stream
// Three instances with different geometries share the stimulus lines; sel picks
// which one receives start and whose outputs are observed. Expected pixels are
// computed by a scatter-add model while elements are driven and queued, then
// popped as the DUT emits pixels.
// -----------------------------------------------------------------------------
module tb_col2im_2d_stream;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;
   int         sel;

   always #5 clk = ~clk;

   logic        st0, st1, st2;
   logic        ir0, ir1, ir2;
   logic        ov0, ov1, ov2;
   logic        ol0, ol1, ol2;
   logic        bz0, bz1, bz2;
   logic        dn0, dn1, dn2;
   logic [11:0] od0;
   logic [11:0] od1;
   logic [3:0]  od2;

   assign st0 = start && (sel == 0);
   assign st1 = start && (sel == 1);
   assign st2 = start && (sel == 2);

   col2im_2d_stream #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .KERNEL_SIZE(3), .STRIDE(1),
                      .DATA_WIDTH(8)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(st0), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_last(ol0),
      .out_ready(out_ready), .busy(bz0), .done(dn0));

   col2im_2d_stream #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(5), .KERNEL_SIZE(3), .STRIDE(2),
                      .DATA_WIDTH(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(st1), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_last(ol1),
      .out_ready(out_ready), .busy(bz1), .done(dn1));

   col2im_2d_stream #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .KERNEL_SIZE(3), .STRIDE(1),
                      .DATA_WIDTH(8), .ACC_WIDTH(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(st2), .in_valid(in_valid), .in_data(in_data),
      .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_last(ol2),
      .out_ready(out_ready), .busy(bz2), .done(dn2));

   logic   ir_m, ov_m, ol_m, bz_m, dn_m;
   longint od_m;

   always_comb begin
      ir_m = ir0; ov_m = ov0; ol_m = ol0; bz_m = bz0; dn_m = dn0; od_m = longint'(od0);
      if (sel == 1) begin
         ir_m = ir1; ov_m = ov1; ol_m = ol1; bz_m = bz1; dn_m = dn1; od_m = longint'(od1);
      end else if (sel == 2) begin
         ir_m = ir2; ov_m = ov2; ol_m = ol2; bz_m = bz2; dn_m = dn2; od_m = longint'(od2);
      end
   end

   int gw, gh, gk, gs, gacc;
   int n_chk  = 0;
   int n_pass = 0;
   longint exp_q[$];
   bit     last_q[$];

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic set_geom(input int s);
      sel = s;
      case (s)
         1:       begin gw = 5; gh = 5; gk = 3; gs = 2; gacc = 12; end
         2:       begin gw = 4; gh = 4; gk = 3; gs = 1; gacc = 4;  end
         default: begin gw = 4; gh = 4; gk = 3; gs = 1; gacc = 12; end
      endcase
   endtask

   // mode 0: all ones, 1: e%256, 2: all 15. abort_at >= 0 stops after that many elements.
   task automatic run_frame(input int mode, input bit in_gap, input int abort_at);
      int hp, vp, nel, cyc;
      longint model [64];
      longint tbl37 [16];
      tbl37 = '{1,2,2,1, 2,4,4,2, 2,4,4,2, 1,2,2,1};
      hp  = (gw - gk) / gs + 1;
      vp  = (gh - gk) / gs + 1;
      nel = hp * vp * gk * gk;
      for (int n = 0; n < 64; n++) model[n] = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int e = 0; e < nel; e++) begin
         int v, p, i, r, c, g;
         if (e == abort_at) begin
            in_valid = 1'b0;
            return;
         end
         v = (mode == 0) ? 1 : (mode == 1) ? (e % 256) : 15;
         p = e / (gk * gk);
         i = e % (gk * gk);
         r = (p / hp) * gs + i / gk;
         c = (p % hp) * gs + i % gk;
         model[r * gw + c] = (model[r * gw + c] + v) % (64'd1 << gacc);
         g = 0;
         while (in_gap && ($urandom_range(0, 1) == 1) && g < 6) begin
            in_valid = 1'b0;
            @(negedge clk);
            g++;
         end
         in_valid = 1'b1;
         in_data  = 8'(v);
         cyc = 0;
         while (!ir_m && cyc < 200) begin
            @(negedge clk);
            cyc++;
         end
         if (cyc >= 200) begin
            chk("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("first_pixel_latency", ov_m, 1);
      for (int n = 0; n < gw * gh; n++) begin
         if (sel == 0 && mode == 0) exp_q.push_back(tbl37[n]);
         else exp_q.push_back(model[n]);
         last_q.push_back(n == gw * gh - 1);
      end
   endtask

   task automatic drain(input bit out_gap);
      int     cyc;
      bit     stalled;
      longint held_d;
      logic   held_l;
      longint e_d;
      bit     e_l;
      cyc = 0;
      stalled = 1'b0;
      held_d = 0;
      held_l = 1'b0;
      while (exp_q.size() > 0 && cyc < 3000) begin
         if (!ov_m) begin
            chk("out_valid_in_drain", ov_m, 1);
            break;
         end
         if (stalled) begin
            chk("hold_data", od_m, held_d);
            chk("hold_last", ol_m, held_l);
         end
         out_ready = out_gap ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_ready) begin
            e_d = exp_q.pop_front();
            e_l = last_q.pop_front();
            chk("pixel", od_m, e_d);
            chk("last_flag", ol_m, e_l);
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held_d  = od_m;
            held_l  = ol_m;
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      chk("drain_left", exp_q.size(), 0);
      exp_q.delete();
      last_q.delete();
      chk("done_pulse", dn_m, 1);
      chk("busy_after", bz_m, 0);
      chk("out_valid_after", ov_m, 0);
      @(negedge clk);
      chk("done_clear", dn_m, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      set_geom(0);
      repeat (3) @(negedge clk);
      chk("rst_in_ready", ir_m, 0);
      chk("rst_out_valid", ov_m, 0);
      chk("rst_busy", bz_m, 0);
      chk("rst_done", dn_m, 0);
      chk("rst_out_data", od_m, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 4x4 K3 S1, all ones, no gaps
      run_frame(0, 1'b0, -1);
      drain(1'b0);
      // ramp e%256
      run_frame(1, 1'b0, -1);
      drain(1'b0);
      // all ones with random gaps on both sides
      run_frame(0, 1'b1, -1);
      drain(1'b1);
      // ramp with gaps
      run_frame(1, 1'b1, -1);
      drain(1'b1);
      // 5x5 K3 S2
      set_geom(1);
      run_frame(0, 1'b0, -1);
      drain(1'b0);
      // 4-bit accumulator wrap
      set_geom(2);
      run_frame(2, 1'b0, -1);
      drain(1'b0);

      // stray in_valid while idle must not disturb the next frame
      set_geom(0);
      in_valid = 1'b1;
      in_data  = 8'd77;
      repeat (4) @(negedge clk);
      chk("idle_in_ready", ir_m, 0);
      in_valid = 1'b0;
      run_frame(0, 1'b0, -1);
      drain(1'b0);

      // abort mid-frame with reset, then a clean frame
      run_frame(1, 1'b0, 20);
      chk("abort_busy", bz_m, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_in_ready", ir_m, 0);
      chk("arst_busy", bz_m, 0);
      chk("arst_out_valid", ov_m, 0);
      chk("arst_out_last", ol_m, 0);
      chk("arst_out_data", od_m, 0);
      chk("arst_done", dn_m, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(0, 1'b0, -1);
      drain(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
